alu_ctrl: RTL and testbench

ALU_CTRL -- requirements
Module: alu_ctrl

---
 rtl/alu_ctrl.sv | 104 ++++++++++
 tb/tb_alu_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl.sv
// Command controller for an external registered ALU: issue, capture, respond.
// Optional ALU_CTRL_STATS_EN builds a saturating completed-response counter on op_count.
module alu_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  input  logic        cmd_chain,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [2:0]  alu_sel,
  input  logic [7:0]  alu_out,
  input  logic        alu_carry,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_data,
  output logic        rsp_carry,
  output logic        busy,
  output logic [15:0] op_count,
  output logic [1:0]  state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // valid never depends on ready, and payload is held stable while valid && !ready.
  typedef enum logic [1:0] {IDLE, ISSUE, CAPT, RESP} state_t;

  state_t     state_q, state_d;
  logic [7:0] acc_q;
  logic       accept;
  logic       rsp_done;

  assign accept   = cmd_valid && (state_q == IDLE);
  assign rsp_done = (state_q == RESP) && rsp_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) state_d = ISSUE;
      end
      ISSUE: state_d = CAPT;
      CAPT:  state_d = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign state_dbg = state_q;

  // ALU operand registers only load on accept, so they hold the last issued values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alu_a   <= 8'h00;
      alu_b   <= 8'h00;
      alu_sel <= 3'b000;
    end else if (accept) begin
      alu_a   <= cmd_chain ? acc_q : cmd_a;
      alu_b   <= cmd_b;
      alu_sel <= cmd_op;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_data  <= 8'h00;
      rsp_carry <= 1'b0;
      acc_q     <= 8'h00;
    end else if (state_q == CAPT) begin
      rsp_data  <= alu_out;
      rsp_carry <= alu_carry;
      acc_q     <= alu_out;
    end
  end

`ifdef ALU_CTRL_STATS_EN
  logic [15:0] op_count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                              op_count_q <= 16'h0000;
    else if (rsp_done && op_count_q != 16'hFFFF) op_count_q <= op_count_q + 16'h0001;
  end

  assign op_count = op_count_q;
`else
  assign op_count = 16'h0000;
`endif

endmodule

// File: tb/tb_alu_ctrl.sv
// Directed bench for alu_ctrl with a behavioural registered ALU and an expected-result queue.
module tb_alu_ctrl;

  logic        clk;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [7:0]  cmd_a;
  logic [7:0]  cmd_b;
  logic        cmd_chain;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [2:0]  alu_sel;
  logic [7:0]  alu_out;
  logic        alu_carry;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_data;
  logic        rsp_carry;
  logic        busy;
  logic [15:0] op_count;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;
  int n_done = 0;
  logic [7:0] model_acc = 8'h00;
  logic [8:0] exp_q[$];

  alu_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_chain(cmd_chain),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_carry(rsp_carry),
    .busy(busy), .op_count(op_count), .state_dbg(state_dbg)
  );

  // Clock/reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // {carry, result}: ADD SUB AND OR XOR NOT SHL SHR
  function automatic logic [8:0] alu_ref(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0:    return {1'b0, a} + {1'b0, b};
      3'd1:    return {1'b0, a} - {1'b0, b};
      3'd2:    return {1'b0, a & b};
      3'd3:    return {1'b0, a | b};
      3'd4:    return {1'b0, a ^ b};
      3'd5:    return {1'b0, ~a};
      3'd6:    return {a, 1'b0};
      default: return {a[0], 1'b0, a[7:1]};
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) {alu_carry, alu_out} <= 9'h000;
    else          {alu_carry, alu_out} <= alu_ref(alu_sel, alu_a, alu_b);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Driver: one command through to its response; hold = cycles of rsp_ready low in RESP.
  task automatic do_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic chain, input logic [8:0] exp, input int hold);
    logic [7:0] exp_a;
    logic [8:0] got;
    logic [8:0] want;
    int n;
    exp_a = chain ? model_acc : a;
    exp_q.push_back(exp);
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
    rsp_ready = (hold == 0);
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_chain = chain; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("issue_regs", {13'd0, alu_sel, alu_a, alu_b}, {13'd0, op, exp_a, b});
    chk("issue_busy_nvalid", {30'd0, busy, rsp_valid}, 32'h2);
    @(posedge clk); #1;
    chk("capt_nvalid", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk); #1;
    chk("latency_valid", {31'd0, rsp_valid}, 32'd1);
    got = {rsp_carry, rsp_data};
    for (int i = 0; i < hold; i++) begin
      cmd_valid = (i % 2 == 0);
      cmd_a = 8'h5A;
      @(posedge clk); #1;
      chk("hold_ctl", {29'd0, rsp_valid, cmd_ready, busy}, 32'h5);
      chk("hold_data", {23'd0, rsp_carry, rsp_data}, {23'd0, got});
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    want = exp_q.pop_front();
    chk("rsp_data", {23'd0, got}, {23'd0, want});
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    n_done++;
    model_acc = want[7:0];
    chk("post_handshake", {30'd0, rsp_valid, cmd_ready}, 32'h1);
    chk("regs_held", {13'd0, alu_sel, alu_a, alu_b}, {13'd0, op, exp_a, b});
  endtask

  initial begin
    logic [2:0] r_op;
    logic [7:0] r_a;
    logic [7:0] r_b;
    logic       r_ch;
    logic       seen;
    reset_n = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_a = 8'h00; cmd_b = 8'h00;
    cmd_chain = 1'b0; rsp_ready = 1'b0;
    #2 reset_n = 1'b0;
    #2;
    chk("reset_ctl", {29'd0, cmd_ready, rsp_valid, busy}, 32'h4);
    chk("reset_rsp", {23'd0, rsp_carry, rsp_data}, 32'h0);
    chk("reset_alu", {13'd0, alu_sel, alu_a, alu_b}, 32'h0);
    chk("reset_count", {16'd0, op_count}, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    do_op(3'd0, 8'hFF, 8'h01, 1'b0, 9'h100, 0);   // ADD wrap
    do_op(3'd1, 8'h05, 8'h07, 1'b0, 9'h1FE, 0);   // SUB borrow
    do_op(3'd6, 8'h81, 8'h00, 1'b0, 9'h102, 0);   // SHL
    do_op(3'd0, 8'h10, 8'h20, 1'b0, 9'h030, 0);
    do_op(3'd0, 8'hAA, 8'h05, 1'b1, 9'h035, 0);   // chained: cmd_a ignored
    do_op(3'd2, 8'h3C, 8'h0F, 1'b0, 9'h00C, 5);   // back-pressure
    do_op(3'd7, 8'h03, 8'h00, 1'b0, 9'h101, 2);   // SHR

    for (int k = 0; k < 6; k++) begin
      r_op = 3'($urandom_range(0, 7));
      r_a  = 8'($urandom_range(0, 255));
      r_b  = 8'($urandom_range(0, 255));
      r_ch = 1'($urandom_range(0, 1));
      do_op(r_op, r_a, r_b, r_ch, alu_ref(r_op, r_ch ? model_acc : r_a, r_b), k % 3);
    end

    // Reset while the command is in ISSUE: nothing may come back from it.
    cmd_op = 3'd0; cmd_a = 8'h44; cmd_b = 8'h11; cmd_chain = 1'b0; cmd_valid = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("mid_issue_busy", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_reset_ctl", {29'd0, cmd_ready, rsp_valid, busy}, 32'h4);
    chk("mid_reset_alu", {13'd0, alu_sel, alu_a, alu_b}, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    model_acc = 8'h00;
    n_done = 0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) seen = 1'b1;
    end
    chk("no_stale_rsp", {31'd0, seen}, 32'd0);
    chk("ready_after_release", {31'd0, cmd_ready}, 32'd1);
    rsp_ready = 1'b0;
    do_op(3'd0, 8'hEE, 8'h03, 1'b1, 9'h003, 0);   // acc cleared by reset
    do_op(3'd4, 8'h0F, 8'hFF, 1'b0, 9'h0F0, 0);
    do_op(3'd3, 8'h80, 8'h01, 1'b1, 9'h0F1, 1);

`ifdef ALU_CTRL_STATS_EN
    chk("op_count", {16'd0, op_count}, n_done);
`else
    chk("op_count", {16'd0, op_count}, 32'd0);
`endif
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
